// File: rtl/sqrt_pkg.sv
// Shared definitions for the fixed-point square-root arbitration logic:
// default data widths and the arbiter FSM state encoding.
package sqrt_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FBITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: selects the first asserted request
// scanning ptr, ptr+1, ... modulo N. Reusable wherever a rotating priority is needed.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    pick,
  output logic [IDXW-1:0] pick_idx,
  output logic            valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[(int'(ptr) + k) % N]) begin
        valid                     = 1'b1;
        pick[(int'(ptr) + k) % N] = 1'b1;
        pick_idx                  = IDXW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one square-root core between N_REQ requesters: round-robin grant,
// one operation in flight, per-requester response pulse and a core watchdog.
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int FBITS   = FBITS_DEF,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_rad,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_root,
  output logic [WIDTH-1:0]       resp_rem,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   core_start,
  output logic [WIDTH-1:0]       core_rad,
  input  logic                   core_busy,
  input  logic                   core_valid,
  input  logic [WIDTH-1:0]       core_root,
  input  logic [WIDTH-1:0]       core_rem
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [WIDTH-1:0]  rad_d;
  logic [N_REQ-1:0]  grant_d, resp_valid_d;
  logic [WIDTH-1:0]  root_d, rem_d;
  logic              err_d, start_d, busy_d;

  logic [N_REQ-1:0]  pick;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_valid;

  // Core status and the Q-format split are informational only at this level.
  logic unused_core_status;
  assign unused_core_status = core_busy ^ (FBITS < 0);

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    rad_d        = core_rad;
    grant_d      = '0;
    resp_valid_d = '0;
    root_d       = '0;
    rem_d        = '0;
    err_d        = 1'b0;
    start_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          idx_d   = pick_idx;
          rad_d   = req_rad[pick_idx*WIDTH +: WIDTH];
          ptr_d   = (pick_idx == IDXW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result on the last permitted cycle beats the watchdog.
        if (core_valid) begin
          root_d       = core_root;
          rem_d        = core_rem;
          resp_valid_d = N_REQ'(1) << idx_q;
          state_d      = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d        = 1'b1;
          resp_valid_d = N_REQ'(1) << idx_q;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      core_rad   <= '0;
      grant      <= '0;
      resp_valid <= '0;
      resp_root  <= '0;
      resp_rem   <= '0;
      resp_err   <= 1'b0;
      core_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      core_rad   <= rad_d;
      grant      <= grant_d;
      resp_valid <= resp_valid_d;
      resp_root  <= root_d;
      resp_rem   <= rem_d;
      resp_err   <= err_d;
      core_start <= start_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter: a behavioural Q8.8 core, a round-robin
// reference model feeding expected queues, and an independent monitor.
module tb_sqrt_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int FB = 8;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_rad;
  logic [N-1:0]   grant, resp_valid;
  logic [W-1:0]   resp_root, resp_rem, core_rad, core_root, core_rem;
  logic           resp_err, busy, core_start, core_busy, core_valid;

  typedef struct {
    int         idx;
    logic [W-1:0] rad;
    logic [W-1:0] root;
    logic [W-1:0] rem;
    bit         err;
  } exp_t;

  exp_t       gq[$];
  exp_t       rq[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  bit         core_stub = 1'b0;
  bit         spur = 1'b0;
  logic [N-1:0] hold = '0;
  int         phase_limit = 0;
  int         phase_grants = 0;

  sqrt_arbiter #(.N_REQ(N), .WIDTH(W), .FBITS(FB), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_rad    (req_rad),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_root  (resp_root),
    .resp_rem   (resp_rem),
    .resp_err   (resp_err),
    .busy       (busy),
    .core_start (core_start),
    .core_rad   (core_rad),
    .core_busy  (core_busy),
    .core_valid (core_valid),
    .core_root  (core_root),
    .core_rem   (core_rem)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: floor square root of the radicand scaled by 2^FB.
  function automatic void ref_sqrt(input logic [W-1:0] rad, output logic [W-1:0] root,
                                   output logic [W-1:0] rem);
    longint x, r;
    x = longint'(rad) * (64'd1 << FB);
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    root = W'(r);
    rem  = W'(x - r * r);
  endfunction

  // Core model uses a bisection search, independent of the reference above.
  function automatic void core_sqrt(input logic [W-1:0] rad, output logic [W-1:0] root,
                                    output logic [W-1:0] rem);
    longint x, lo, hi, mid;
    x  = longint'(rad) << FB;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    root = W'(lo);
    rem  = W'(x - lo * lo);
  endfunction

  initial begin : core_model
    int           cnt;
    logic [W-1:0] rad_l;
    cnt = 0;
    rad_l = '0;
    core_valid = 1'b0;
    core_busy  = 1'b0;
    core_root  = '0;
    core_rem   = '0;
    forever begin
      @(posedge clk);
      #1;
      core_valid = 1'b0;
      core_root  = '0;
      core_rem   = '0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_busy = 1'b0;
          if (!core_stub) begin
            core_valid = 1'b1;
            core_sqrt(rad_l, core_root, core_rem);
          end
        end
      end
      if (spur) begin
        spur       = 1'b0;
        core_valid = 1'b1;
        core_root  = 16'hDEAD;
        core_rem   = 16'hBEEF;
      end
      if (core_start) begin
        rad_l     = core_rad;
        cnt       = $urandom_range(6, 1);
        core_busy = 1'b1;
      end
    end
  end

  // Requesters release their request on grant unless told to keep asking.
  initial forever begin
    @(posedge clk);
    #1;
    if (grant != '0) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          phase_grants++;
          if (!hold[i] || phase_grants >= phase_limit) req[i] = 1'b0;
        end
      end
      if (phase_grants >= phase_limit) req = '0;
    end
  end

  initial begin : monitor
    int           last_grant, last_start, last_cv;
    bit           pend;
    logic [W-1:0] exp_rad;
    exp_t         e;
    last_grant = -100;
    last_start = -100;
    last_cv    = -100;
    pend       = 1'b0;
    exp_rad    = '0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (core_valid) last_cv = cyc;
      if (grant != '0) begin
        if (gq.size() == 0) check("unexpected_grant", 32'(grant), 32'd0);
        else begin
          e = gq.pop_front();
          check("grant", 32'(grant), 32'd1 << e.idx);
          exp_rad    = e.rad;
          last_grant = cyc;
          pend       = 1'b1;
        end
      end
      if (core_start) begin
        check("start_after_grant", 32'(pend && (cyc - last_grant == 1)), 32'd1);
        check("core_rad", 32'(core_rad), 32'(exp_rad));
        pend       = 1'b0;
        last_start = cyc;
      end
      if (resp_valid != '0) begin
        if (rq.size() == 0) check("unexpected_resp", 32'(resp_valid), 32'd0);
        else begin
          e = rq.pop_front();
          check("resp_valid", 32'(resp_valid), 32'd1 << e.idx);
          check("resp_root", 32'(resp_root), 32'(e.root));
          check("resp_rem", 32'(resp_rem), 32'(e.rem));
          check("resp_err", 32'(resp_err), 32'(e.err));
          if (e.err) check("timeout_latency", 32'(cyc - last_start), 32'(TO));
          else       check("resp_latency", 32'(cyc - last_cv), 32'd1);
        end
      end else begin
        check("resp_idle_zero", 32'((resp_root != '0) || (resp_rem != '0) || resp_err), 32'd0);
      end
    end
  end

  // Round-robin reference: each op serves the first live requester from the pointer.
  task automatic plan(input logic [N-1:0] mask, input logic [N-1:0] hold_m, input int n_ops);
    logic [N-1:0] live;
    int           sel;
    exp_t         e;
    live = mask;
    for (int op = 0; op < n_ops && live != '0; op++) begin
      sel = -1;
      for (int k = 0; k < N; k++)
        if (sel < 0 && live[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      m_ptr = (sel + 1) % N;
      if (!hold_m[sel]) live[sel] = 1'b0;
      e.idx = sel;
      e.rad = req_rad[sel*W +: W];
      e.err = core_stub;
      if (core_stub) begin
        e.root = '0;
        e.rem  = '0;
      end else ref_sqrt(e.rad, e.root, e.rem);
      gq.push_back(e);
      rq.push_back(e);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int c;
    c = 0;
    while ((gq.size() != 0 || rq.size() != 0) && c < max_cyc) begin
      @(posedge clk);
      c++;
    end
    if (gq.size() != 0 || rq.size() != 0) begin
      check("phase_complete", 32'(gq.size() + rq.size()), 32'd0);
      gq.delete();
      rq.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_phase(input logic [N-1:0] mask, input logic [N-1:0] hold_m,
                           input int n_ops, input logic [N*W-1:0] rads);
    req_rad      = rads;
    hold         = hold_m;
    phase_limit  = n_ops;
    phase_grants = 0;
    plan(mask, hold_m, n_ops);
    req = mask;
    wait_done(n_ops * (TO + 10) + 20);
    req  = '0;
    hold = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_root"}, 32'(resp_root), 32'd0);
    check({tag, "_resp_rem"}, 32'(resp_rem), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_core_rad"}, 32'(core_rad), 32'd0);
  endtask

  initial begin
    logic [N-1:0] mask;
    req     = '0;
    req_rad = '0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_phase(4'b0001, 4'b0000, 1, {48'h0, 16'hE890});
    run_phase(4'b1000, 4'b0000, 1, {16'h1234, 48'h0});
    run_phase(4'b1111, 4'b0000, 4, {16'h0400, 16'h0100, 16'h0200, 16'h0040});
    run_phase(4'b0010, 4'b0000, 1, {32'h0, 16'h0321, 16'h0});
    run_phase(4'b1010, 4'b0000, 2, {16'h0900, 16'h0, 16'h0190, 16'h0});

    core_stub = 1'b1;
    run_phase(4'b0100, 4'b0000, 1, {16'h0, 16'h0510, 32'h0});
    core_stub = 1'b0;
    run_phase(4'b0100, 4'b0000, 1, {16'h0, 16'h0510, 32'h0});

    run_phase(4'b0011, 4'b0011, 4, {32'h0, 16'h0A00, 16'h0B00});

    for (int i = 0; i < 12; i++) begin
      mask = N'($urandom_range(15, 1));
      run_phase(mask, 4'b0000, $countones(mask), {$urandom, $urandom});
    end

    spur = 1'b1;
    run_phase(4'b0001, 4'b0000, 1, {48'h0, 16'h7F00});

    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("spur_idle_busy", 32'(busy), 32'd0);

    run_phase(4'b0110, 4'b0000, 1, {16'h0, 16'h0C40, 16'h0A90, 16'h0});
    check("withdraw_busy", 32'(busy), 32'd0);
    check("withdraw_grant", 32'(grant), 32'd0);

    core_stub    = 1'b1;
    req_rad      = {48'h0, 16'h0900};
    phase_limit  = 1;
    phase_grants = 0;
    plan(4'b0001, 4'b0000, 1);
    req = 4'b0001;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    check("abort_grant_seen", 32'(gq.size()), 32'd0);
    gq.delete();
    rq.delete();
    req   = '0;
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_abort_busy", 32'(busy), 32'd0);
    core_stub = 1'b0;
    run_phase(4'b0100, 4'b0000, 1, {16'h0, 16'h0100, 32'h0});

    check("queues_drained", 32'(gq.size() + rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
